// File: rtl/mining_pkg.sv
// Shared types and widths for the hash-checker result path.
package mining_pkg;

    localparam int unsigned NONCE_W  = 32;
    localparam int unsigned ROUND_W  = 6;
    localparam int unsigned FLAG_BIT = 32;

    typedef logic [NONCE_W-1:0] nonce_t;
    typedef logic [ROUND_W-1:0] round_t;

    // Sample edge detector: ARMED until the round count sits on the sample point.
    typedef enum logic {
        DET_ARMED = 1'b0,
        DET_SEEN  = 1'b1
    } det_state_t;

endpackage

// File: rtl/nonce_fifo.sv
// Winning-nonce buffer; a push while full is accepted only alongside a pop.
module nonce_fifo
    import mining_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               push,
    input  logic [NONCE_W-1:0] push_data,
    input  logic               pop,
    output logic [NONCE_W-1:0] rd_data,
    output logic               empty,
    output logic               full
);

    localparam int unsigned AW = $clog2(DEPTH);

    nonce_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    occ;
    logic           do_pop;
    logic           do_push;

    assign empty   = (occ == '0);
    assign full    = (occ == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                occ <= occ + 1'b1;
            end else if (do_pop && !do_push) begin
                occ <= occ - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nonce_reporter.sv
// Samples {flag, nonce} once per hash iteration, buffers winners for the host
// and keeps tried/found statistics plus a sticky overflow flag.
module nonce_reporter
    import mining_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter round_t      SAMPLE_COUNT = 6'd63
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [ROUND_W-1:0] count,
    input  logic [NONCE_W:0]   flag_plus_nonce,
    input  logic               host_ready,
    input  logic               overflow_clr,
    output logic               host_valid,
    output logic [NONCE_W-1:0] host_nonce,
    output logic               halt,
    output logic               overflow,
    output logic [31:0]        tried_count,
    output logic [15:0]        found_count
);

    round_t     prev_count;
    det_state_t det;
    logic       sample;
    logic       push_req;
    logic       pop;
    logic       empty;
    logic       full;
    logic       drop;

    // The detector state is carried by prev_count rather than a separate register.
    assign det      = (prev_count == SAMPLE_COUNT) ? DET_SEEN : DET_ARMED;
    assign sample   = (count == SAMPLE_COUNT) && (det == DET_ARMED);
    assign push_req = sample && flag_plus_nonce[FLAG_BIT];
    assign pop      = !empty && host_ready;
    assign drop     = push_req && full && !pop;

    assign host_valid = !empty;
    assign halt       = full;

    nonce_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (push_req),
        .push_data(flag_plus_nonce[NONCE_W-1:0]),
        .pop      (pop),
        .rd_data  (host_nonce),
        .empty    (empty),
        .full     (full)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_count  <= '0;
            tried_count <= '0;
            found_count <= '0;
            overflow    <= 1'b0;
        end else begin
            prev_count <= count;
            if (sample) begin
                tried_count <= tried_count + 32'd1;
            end
            if (push_req && (found_count != '1)) begin
                found_count <= found_count + 16'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nonce_reporter.sv
// Directed bench for nonce_reporter with a queue-based reference model.
module tb_nonce_reporter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [5:0]  count = 6'd0;
    logic [32:0] fpn = 33'd0;
    logic        host_ready = 1'b0;
    logic        overflow_clr = 1'b0;

    logic        host_valid, halt, overflow;
    logic [31:0] host_nonce, tried_count;
    logic [15:0] found_count;

    logic        host_valid2, halt2, overflow2;
    logic [31:0] host_nonce2, tried_count2;
    logic [15:0] found_count2;

    nonce_reporter #(
        .DEPTH(DEPTH),
        .SAMPLE_COUNT(6'd63)
    ) dut (
        .clk(clk), .n_rst(n_rst), .count(count), .flag_plus_nonce(fpn),
        .host_ready(host_ready), .overflow_clr(overflow_clr),
        .host_valid(host_valid), .host_nonce(host_nonce), .halt(halt),
        .overflow(overflow), .tried_count(tried_count), .found_count(found_count)
    );

    nonce_reporter #(
        .DEPTH(DEPTH),
        .SAMPLE_COUNT(6'd0)
    ) dut0 (
        .clk(clk), .n_rst(n_rst), .count(count), .flag_plus_nonce(fpn),
        .host_ready(host_ready), .overflow_clr(overflow_clr),
        .host_valid(host_valid2), .host_nonce(host_nonce2), .halt(halt2),
        .overflow(overflow2), .tried_count(tried_count2), .found_count(found_count2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model for the SAMPLE_COUNT=63 instance.
    logic [5:0]  m_prev = 6'd0;
    logic [31:0] q[$];
    logic [31:0] m_tried = 32'd0;
    logic [15:0] m_found = 16'd0;
    logic        m_ovf = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q.delete();
            m_prev  = 6'd0;
            m_tried = 32'd0;
            m_found = 16'd0;
            m_ovf   = 1'b0;
        end else begin
            bit smp, pp, ps, dr;
            smp = (count == 6'd63) && (m_prev != 6'd63);
            ps  = smp && fpn[32];
            pp  = (q.size() != 0) && host_ready;
            dr  = ps && (q.size() == DEPTH) && !pp;
            if (smp) m_tried = m_tried + 1;
            if (ps && m_found != 16'hFFFF) m_found = m_found + 1;
            if (pp) void'(q.pop_front());
            if (ps && !dr) q.push_back(fpn[31:0]);
            if (dr) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            m_prev = count;
        end
    end

    always @(negedge clk) begin
        chk("host_valid", {31'b0, host_valid}, {31'b0, (q.size() != 0)});
        chk("host_nonce", host_nonce, (q.size() != 0) ? q[0] : 32'd0);
        chk("halt", {31'b0, halt}, {31'b0, (q.size() == DEPTH)});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("tried_count", tried_count, m_tried);
        chk("found_count", {16'b0, found_count}, {16'b0, m_found});
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic win(input logic [31:0] n, input logic rdy, input logic clr);
        count = 6'd62; fpn = '0; host_ready = 1'b0; overflow_clr = 1'b0;
        tick();
        count = 6'd63; fpn = {1'b1, n}; host_ready = rdy; overflow_clr = clr;
        tick();
        count = 6'd0; fpn = '0; host_ready = 1'b0; overflow_clr = 1'b0;
    endtask

    task automatic drain_expect(input logic [31:0] n);
        chk("drain_valid", {31'b0, host_valid}, 32'd1);
        chk("drain_nonce", host_nonce, n);
        host_ready = 1'b1;
        tick();
        host_ready = 1'b0;
    endtask

    // Async reset pulse placed between edges: assert, observe, release.
    task automatic pulse_reset;
        #1 n_rst = 1'b0;
        #1;
        chk("rst_valid", {31'b0, host_valid}, 32'd0);
        chk("rst_nonce", host_nonce, 32'd0);
        chk("rst_halt", {31'b0, halt}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_tried", tried_count, 32'd0);
        chk("rst_found", {16'b0, found_count}, 32'd0);
        n_rst = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        chk("reset_tried", tried_count, 32'd0);
        chk("reset_valid", {31'b0, host_valid}, 32'd0);
        n_rst = 1'b1;

        // 1: two full sweeps without winners
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 64; i++) begin
                count = 6'(i);
                tick();
            end
        end
        chk("t1_tried", tried_count, 32'd2);
        chk("t1_model_tried", m_tried, 32'd2);
        chk("t1_found", {16'b0, found_count}, 32'd0);
        chk("t1_valid", {31'b0, host_valid}, 32'd0);
        chk("t1_halt", {31'b0, halt}, 32'd0);

        // 2: dwell at 63 yields one push
        count = 6'd62; tick();
        count = 6'd63; fpn = {1'b1, 32'hDEADBEEF};
        tick();
        chk("t2_valid", {31'b0, host_valid}, 32'd1);
        chk("t2_nonce", host_nonce, 32'hDEADBEEF);
        repeat (4) tick();
        chk("t2_found", {16'b0, found_count}, 32'd1);
        chk("t2_tried", tried_count, 32'd3);
        chk("t2_model_qsize", q.size(), 32'd1);
        count = 6'd0; fpn = '0; host_ready = 1'b1;
        tick();
        host_ready = 1'b0;
        chk("t2_popped", {31'b0, host_valid}, 32'd0);

        // 3: fill, overflow, drain in order
        pulse_reset();
        for (int n = 1; n <= 4; n++) win(32'(n), 1'b0, 1'b0);
        chk("t3_halt", {31'b0, halt}, 32'd1);
        chk("t3_ovf0", {31'b0, overflow}, 32'd0);
        win(32'd5, 1'b0, 1'b0);
        chk("t3_ovf", {31'b0, overflow}, 32'd1);
        chk("t3_found", {16'b0, found_count}, 32'd5);
        chk("t3_model_found", {16'b0, m_found}, 32'd5);
        for (int n = 1; n <= 4; n++) drain_expect(32'(n));
        chk("t3_empty", {31'b0, host_valid}, 32'd0);
        chk("t3_halt_low", {31'b0, halt}, 32'd0);

        // 6a: clear alone
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
        chk("t6_clr", {31'b0, overflow}, 32'd0);

        // 4: push at full with simultaneous pop
        for (int n = 1; n <= 4; n++) win(32'(n), 1'b0, 1'b0);
        win(32'd9, 1'b1, 1'b0);
        chk("t4_ovf", {31'b0, overflow}, 32'd0);
        chk("t4_halt", {31'b0, halt}, 32'd1);
        chk("t4_found", {16'b0, found_count}, 32'd10);
        drain_expect(32'd2);
        drain_expect(32'd3);
        drain_expect(32'd4);
        drain_expect(32'd9);
        chk("t4_empty", {31'b0, host_valid}, 32'd0);

        // 6b: clear loses against a same-cycle drop
        for (int n = 11; n <= 14; n++) win(32'(n), 1'b0, 1'b0);
        win(32'd15, 1'b0, 1'b1);
        chk("t6_set_wins", {31'b0, overflow}, 32'd1);
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
        chk("t6_clr2", {31'b0, overflow}, 32'd0);

        // 5: reset mid-transfer, then SAMPLE_COUNT=0 first-cycle case
        for (int n = 11; n <= 14; n++) drain_expect(32'(n));
        win(32'd21, 1'b0, 1'b0);
        win(32'd22, 1'b0, 1'b0);
        chk("t5_pre_nonce", host_nonce, 32'd21);
        count = 6'd0;
        pulse_reset();
        tick();
        chk("t5_sc0_first", tried_count2, 32'd0);
        tick();
        chk("t5_sc0_dwell", tried_count2, 32'd0);
        count = 6'd1; tick();
        count = 6'd0; tick();
        chk("t5_sc0_event", tried_count2, 32'd1);
        chk("t5_sc0_valid", {31'b0, host_valid2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
